ms_fifo_bridge: RTL and testbench

//  Parametrised buffered link between a master and a slave on the ms_if valid/ready bus.

---
 rtl/ms_fifo_bridge.sv | 87 ++++++++
 tb/tb_ms_fifo_bridge.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ms_fifo_bridge.sv
// rtl/ms_fifo_bridge.sv - buffered valid/ready bridge: DEPTH-entry {addr,data} FIFO with flush, almost-full and beat counter
module ms_fifo_bridge #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     s_valid,
    input  logic [ADDR_W-1:0]        s_addr,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic [15:0]              beat_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   beat_cnt_q, beat_cnt_d;
    logic          push, pop;

    // Handshake flags are pure functions of registered state plus rstn.
    assign s_ready     = rstn & (count_q != DEPTH_C);
    assign m_valid     = rstn & (count_q != '0);
    assign almost_full = rstn & (count_q >= AF_C);
    assign {m_addr, m_data} = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign beat_cnt    = beat_cnt_q;

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q + {15'd0, push};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Storage needs no reset; a write during flush lands in a slot that is then considered empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_addr, s_data};
    end

endmodule

// File: tb/tb_ms_fifo_bridge.sv
// tb/tb_ms_fifo_bridge.sv - directed self-checking bench for ms_fifo_bridge
module tb_ms_fifo_bridge;

    logic        clk = 1'b0;
    logic        rstn, flush, s_valid, s_ready, m_valid, m_ready, almost_full;
    logic [7:0]  s_addr, s_data, m_addr, m_data;
    logic [2:0]  count;
    logic [15:0] beat_cnt;
    int          passed = 0;
    int          total  = 0;

    ms_fifo_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .AF_LEVEL(3)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .count(count), .almost_full(almost_full), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input logic [7:0] a, input logic [7:0] d);
        s_valid = 1'b1; s_addr = a; s_data = d;
        step();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_addr = '0; s_data = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready cyc%0d got %b want 0", i, s_ready); else passed++;
            total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid cyc%0d got %b want 0", i, m_valid); else passed++;
        end
        rstn = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1) $display("FAIL post_rst_s_ready got %b want 1", s_ready); else passed++;
        total++; if (m_valid !== 1'b0) $display("FAIL post_rst_m_valid got %b want 0", m_valid); else passed++;
        total++; if (count !== 3'd0) $display("FAIL post_rst_count got %0d want 0", count); else passed++;
        total++; if (beat_cnt !== 16'd0) $display("FAIL post_rst_beat_cnt got %0d want 0", beat_cnt); else passed++;
    endtask

    task automatic test_fill();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_idle(8'h10 + 8'(i), 8'hA0 + 8'(i));
            total++; if (count !== 3'(i + 1)) $display("FAIL fill_count %0d got %0d want %0d", i, count, i + 1); else passed++;
            total++; if (almost_full !== (i >= 2)) $display("FAIL fill_af %0d got %b want %b", i, almost_full, i >= 2); else passed++;
        end
        total++; if (s_ready !== 1'b0) $display("FAIL full_s_ready got %b want 0", s_ready); else passed++;
        s_valid = 1'b1; s_addr = 8'h14; s_data = 8'hA4;
        step(); step();
        total++; if (count !== 3'd4) $display("FAIL full_hold_count got %0d want 4", count); else passed++;
        total++; if (beat_cnt !== 16'd4) $display("FAIL full_hold_beat_cnt got %0d want 4", beat_cnt); else passed++;
        total++; if ({m_addr, m_data} !== 16'h10A0) $display("FAIL full_head got %h want 10a0", {m_addr, m_data}); else passed++;
    endtask

    task automatic test_drain();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_addr !== 8'h10 + 8'(i) || m_data !== 8'hA0 + 8'(i))
                $display("FAIL drain_head %0d got v=%b %h/%h want v=1 %h/%h", i, m_valid, m_addr, m_data, 8'h10 + 8'(i), 8'hA0 + 8'(i));
            else passed++;
            step();
            // the held beat is taken at the second pop edge (first edge freed a slot)
            if (i == 1) s_valid = 1'b0;
        end
        total++; if (m_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", m_valid); else passed++;
        total++; if (count !== 3'd0) $display("FAIL drain_count got %0d want 0", count); else passed++;
        total++; if (beat_cnt !== 16'd5) $display("FAIL drain_beat_cnt got %0d want 5", beat_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        push_idle(8'h20, 8'h30);
        push_idle(8'h21, 8'h31);
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            s_addr = 8'h22 + 8'(j); s_data = 8'h32 + 8'(j);
            total++;
            if (m_addr !== 8'h20 + 8'(j) || m_data !== 8'h30 + 8'(j))
                $display("FAIL b2b_head %0d got %h/%h want %h/%h", j, m_addr, m_data, 8'h20 + 8'(j), 8'h30 + 8'(j));
            else passed++;
            step();
            total++; if (count !== 3'd2) $display("FAIL b2b_count %0d got %0d want 2", j, count); else passed++;
        end
        s_valid = 1'b0;
        for (int j = 10; j < 12; j++) begin
            total++;
            if (m_addr !== 8'h20 + 8'(j) || m_data !== 8'h30 + 8'(j))
                $display("FAIL b2b_tail %0d got %h/%h want %h/%h", j, m_addr, m_data, 8'h20 + 8'(j), 8'h30 + 8'(j));
            else passed++;
            step();
        end
        total++; if (count !== 3'd0) $display("FAIL b2b_final_count got %0d want 0", count); else passed++;
        total++; if (beat_cnt !== 16'd17) $display("FAIL b2b_beat_cnt got %0d want 17", beat_cnt); else passed++;
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_idle(8'h40 + 8'(k), 8'h50 + 8'(k));
        total++; if (count !== 3'd3) $display("FAIL flush_pre_count got %0d want 3", count); else passed++;
        flush = 1'b1; s_valid = 1'b1; s_addr = 8'h4F; s_data = 8'h5F;
        step();
        flush = 1'b0; s_valid = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else passed++;
        total++; if (m_valid !== 1'b0) $display("FAIL flush_m_valid got %b want 0", m_valid); else passed++;
        total++; if (beat_cnt !== 16'd21) $display("FAIL flush_beat_cnt got %0d want 21", beat_cnt); else passed++;
        push_idle(8'h60, 8'h70);
        total++; if (count !== 3'd1) $display("FAIL flush_next_count got %0d want 1", count); else passed++;
        total++; if ({m_addr, m_data} !== 16'h6070) $display("FAIL flush_next_head got %h want 6070", {m_addr, m_data}); else passed++;
        m_ready = 1'b1;
        step();
        total++; if (m_valid !== 1'b0) $display("FAIL flush_next_alone got %b want 0", m_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_idle(8'h80 + 8'(k), 8'h90 + 8'(k));
        rstn = 1'b0;
        step();
        total++; if (count !== 3'd0) $display("FAIL midrst_count got %0d want 0", count); else passed++;
        total++; if (beat_cnt !== 16'd0) $display("FAIL midrst_beat_cnt got %0d want 0", beat_cnt); else passed++;
        total++; if (s_ready !== 1'b0) $display("FAIL midrst_s_ready got %b want 0", s_ready); else passed++;
        rstn = 1'b1;
        push_idle(8'hC0, 8'hD0);
        total++;
        if (m_valid !== 1'b1 || {m_addr, m_data} !== 16'hC0D0)
            $display("FAIL midrst_first got v=%b %h want v=1 c0d0", m_valid, {m_addr, m_data});
        else passed++;
        total++; if (beat_cnt !== 16'd1) $display("FAIL midrst_beat_after got %0d want 1", beat_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
